control_unit: RTL and testbench

- Hardwired control sequencer for the RISC CPU datapath.
- Drives every register-transfer, ALU, memory and I/O strobe that benches currently drive by hand.
- Runs the fetch sequence T0–T2, then T3–T7 according to IR[31:27]; returns to T0 or halts.
- Sits beside CPU, consumes IR and CON from it, and replaces manual sequencing.

---
 rtl/cpu_ctrl_pkg.sv | 22 ++
 rtl/cu_decode.sv | 22 ++
 rtl/control_unit.sv | 90 +++++++++
 tb/tb_control_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, sequencer state encoding and instruction classes for the control unit
package cpu_ctrl_pkg;
  localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3, OP_SUB = 5'd4;
  localparam logic [4:0] OP_SHR = 5'd5, OP_SHRA = 5'd6, OP_SHL = 5'd7, OP_ROR = 5'd8, OP_ROL = 5'd9;
  localparam logic [4:0] OP_AND = 5'd10, OP_OR = 5'd11, OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI = 5'd14;
  localparam logic [4:0] OP_MUL = 5'd15, OP_DIV = 5'd16, OP_NEG = 5'd17, OP_NOT = 5'd18, OP_BR = 5'd19;
  localparam logic [4:0] OP_JR = 5'd20, OP_JAL = 5'd21, OP_IN = 5'd22, OP_OUT = 5'd23, OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25, OP_NOP = 5'd26, OP_HALT = 5'd27;
  localparam logic [3:0] S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4;
  localparam logic [3:0] S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9;
  localparam logic [3:0] C_ALU = 4'd0, C_IMM = 4'd1, C_UNARY = 4'd2, C_MULDIV = 4'd3, C_LD = 4'd4;
  localparam logic [3:0] C_LDI = 4'd5, C_ST = 4'd6, C_BR = 4'd7, C_JR = 4'd8, C_JAL = 4'd9;
  localparam logic [3:0] C_IN = 4'd10, C_OUT = 4'd11, C_MFHI = 4'd12, C_MFLO = 4'd13, C_NOP = 4'd14;
  localparam logic [3:0] C_HALT = 4'd15;
  // Final execute step of each class; the sequencer returns to T0 after it
  function automatic logic [3:0] last_state(input logic [3:0] cls);
    return (cls == C_MULDIV || cls == C_BR) ? S_T6 :
           (cls == C_LD || cls == C_ST) ? S_T7 :
           (cls == C_ALU || cls == C_IMM || cls == C_LDI) ? S_T5 :
           (cls == C_UNARY || cls == C_JAL) ? S_T4 : S_T3;
  endfunction
endpackage

// File: rtl/cu_decode.sv
// cu_decode: maps an opcode to its instruction class and ALU function select
module cu_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output logic [3:0] cls,
  output logic [4:0] alu_op
);
  always_comb begin
    cls = (opcode >= OP_ADD && opcode <= OP_OR) ? C_ALU :
          (opcode >= OP_ADDI && opcode <= OP_ORI) ? C_IMM :
          (opcode == OP_NEG || opcode == OP_NOT) ? C_UNARY :
          (opcode == OP_MUL || opcode == OP_DIV) ? C_MULDIV :
          opcode == OP_LD ? C_LD : opcode == OP_LDI ? C_LDI : opcode == OP_ST ? C_ST :
          opcode == OP_BR ? C_BR : opcode == OP_JR ? C_JR : opcode == OP_JAL ? C_JAL :
          opcode == OP_IN ? C_IN : opcode == OP_OUT ? C_OUT :
          opcode == OP_MFHI ? C_MFHI : opcode == OP_MFLO ? C_MFLO :
          opcode == OP_HALT ? C_HALT : C_NOP;
    alu_op = opcode == OP_ADDI ? OP_ADD : opcode == OP_ANDI ? OP_AND :
             opcode == OP_ORI ? OP_OR : opcode;
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/execute sequencer driving the RISC datapath strobes
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int IR_W = 32,
  parameter int OP_W = 5
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [IR_W-1:0] ir,
  input  logic            CON,
  output logic            run,
  output logic [OP_W-1:0] alu_op,
  output logic            PCout, PCin, IncPC, MARin, MDRin, MDRout, memRead, memWrite,
  output logic            ramEnable, IRin, Yin, Zin, Zhighout, Zlowout, HIin, LOin, HIout,
  output logic            LOout, Cout, BAout, Gra, Grb, Grc, Rin, Rout, R15in, CONin,
  output logic            InPort_Out, OutPort_In
);
  logic [3:0] state_q, state_d, cls;
  logic [4:0] dec_alu;
  logic unused_ir;
  assign unused_ir = ^ir[IR_W-OP_W-1:0];
  cu_decode u_dec (.opcode(ir[IR_W-1 -: OP_W]), .cls(cls), .alu_op(dec_alu));
  always_comb begin
    state_d = state_q == S_RESET ? S_T0 :
              state_q >= S_HALT ? state_q == S_HALT ? S_HALT : S_RESET :
              state_q == S_T2 ? (cls == C_HALT ? S_HALT : cls == C_NOP ? S_T0 : S_T3) :
              (state_q >= S_T3 && state_q == last_state(cls)) ? S_T0 : state_q + 4'd1;
  end
  always_ff @(posedge clock) begin
    if (!clear) state_q <= S_RESET;
    else state_q <= state_d;
  end
  always_comb begin
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, memRead, memWrite, ramEnable, IRin, Yin, Zin,
     Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout, BAout, Gra, Grb, Grc, Rin, Rout,
     R15in, CONin, InPort_Out, OutPort_In} = '0;
    alu_op = OP_ADD;
    run = state_q != S_RESET && state_q != S_HALT;
    unique case (state_q)
      S_T0: {PCout, MARin, IncPC, Zin} = '1;
      S_T1: {Zlowout, PCin, memRead, MDRin, ramEnable} = '1;
      S_T2: {MDRout, IRin} = '1;
      S_T3: unique case (cls)
        C_ALU, C_IMM: {Grb, Rout, Yin} = '1;
        C_UNARY: begin {Grb, Rout, Zin} = '1; alu_op = dec_alu; end
        C_MULDIV: {Gra, Rout, Yin} = '1;
        C_LD, C_LDI, C_ST: {Grb, BAout, Yin} = '1;
        C_BR: {Gra, Rout, CONin} = '1;
        C_JR: {Gra, Rout, PCin} = '1;
        C_JAL: {PCout, R15in} = '1;
        C_IN: {InPort_Out, Gra, Rin} = '1;
        C_OUT: {Gra, Rout, OutPort_In} = '1;
        C_MFHI: {HIout, Gra, Rin} = '1;
        C_MFLO: {LOout, Gra, Rin} = '1;
        default: ;
      endcase
      S_T4: unique case (cls)
        C_ALU: begin {Grc, Rout, Zin} = '1; alu_op = dec_alu; end
        C_IMM: begin {Cout, Zin} = '1; alu_op = dec_alu; end
        C_UNARY: {Zlowout, Gra, Rin} = '1;
        C_MULDIV: begin {Grb, Rout, Zin} = '1; alu_op = dec_alu; end
        C_LD, C_LDI, C_ST: {Cout, Zin} = '1;
        C_BR: {PCout, Yin} = '1;
        C_JAL: {Gra, Rout, PCin} = '1;
        default: ;
      endcase
      S_T5: unique case (cls)
        C_ALU, C_IMM, C_LDI: {Zlowout, Gra, Rin} = '1;
        C_MULDIV: {Zlowout, LOin} = '1;
        C_LD, C_ST: {Zlowout, MARin} = '1;
        C_BR: {Cout, Zin} = '1;
        default: ;
      endcase
      S_T6: unique case (cls)
        C_MULDIV: {Zhighout, HIin} = '1;
        C_LD: {memRead, MDRin, ramEnable} = '1;
        C_ST: {Gra, Rout, MDRin} = '1;
        C_BR: begin Zlowout = 1'b1; PCin = CON; end
        default: ;
      endcase
      S_T7: unique case (cls)
        C_LD: {MDRout, Gra, Rin} = '1;
        C_ST: {memWrite, ramEnable} = '1;
        default: ;
      endcase
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed per-cycle strobe vectors checked through an expectation queue
module tb_control_unit;
  localparam logic [28:0] PCOUT = 29'h1 << 0, PCIN = 29'h1 << 1, INCPC = 29'h1 << 2, MARIN = 29'h1 << 3;
  localparam logic [28:0] MDRIN = 29'h1 << 4, MDROUT = 29'h1 << 5, MEMREAD = 29'h1 << 6, MEMWRITE = 29'h1 << 7;
  localparam logic [28:0] RAMEN = 29'h1 << 8, IRIN = 29'h1 << 9, YIN = 29'h1 << 10, ZIN = 29'h1 << 11;
  localparam logic [28:0] ZHIGH = 29'h1 << 12, ZLOW = 29'h1 << 13, HIIN = 29'h1 << 14, LOIN = 29'h1 << 15;
  localparam logic [28:0] HIOUT = 29'h1 << 16, LOOUT = 29'h1 << 17, COUT = 29'h1 << 18, BAOUT = 29'h1 << 19;
  localparam logic [28:0] GRA = 29'h1 << 20, GRB = 29'h1 << 21, GRC = 29'h1 << 22, RIN = 29'h1 << 23;
  localparam logic [28:0] ROUT = 29'h1 << 24, R15IN = 29'h1 << 25, CONIN = 29'h1 << 26;
  localparam logic [28:0] INP = 29'h1 << 27, OUTP = 29'h1 << 28;
  localparam logic [4:0] ADD = 5'd3;
  typedef struct {
    string n;
    logic [34:0] v;
  } exp_t;
  exp_t q[$];
  logic clock = 0, clear, CON, run;
  logic [31:0] ir;
  logic [4:0] alu_op;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, memRead, memWrite, ramEnable, IRin, Yin, Zin;
  logic Zhighout, Zlowout, HIin, LOin, HIout, LOout, Cout, BAout, Gra, Grb, Grc, Rin, Rout;
  logic R15in, CONin, InPort_Out, OutPort_In;
  logic [34:0] obs;
  int errors = 0, checks = 0;
  always #5 clock = ~clock;
  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .CON(CON), .run(run), .alu_op(alu_op),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .memRead(memRead), .memWrite(memWrite), .ramEnable(ramEnable), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin), .HIout(HIout),
    .LOout(LOout), .Cout(Cout), .BAout(BAout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .R15in(R15in), .CONin(CONin), .InPort_Out(InPort_Out), .OutPort_In(OutPort_In)
  );
  assign obs = {run, alu_op, OutPort_In, InPort_Out, CONin, R15in, Rout, Rin, Grc, Grb, Gra, BAout,
                Cout, LOout, HIout, LOin, HIin, Zlowout, Zhighout, Zin, Yin, IRin, ramEnable,
                memWrite, memRead, MDRout, MDRin, MARin, IncPC, PCin, PCout};
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got run/alu/strobes=%h expected %h", e.n, obs, e.v);
      end
    end
  end
  task automatic cyc(input string n, input logic [28:0] s, input logic [4:0] a = ADD, input logic r = 1'b1);
    exp_t e;
    e.n = n;
    e.v = {r, a, s};
    q.push_back(e);
    @(posedge clock);
    #1;
  endtask
  task automatic fetch(input logic [31:0] instr);
    ir = instr;
    cyc("T0", PCOUT | MARIN | INCPC | ZIN);
    cyc("T1", ZLOW | PCIN | MEMREAD | MDRIN | RAMEN);
    cyc("T2", MDROUT | IRIN);
  endtask
  initial begin
    clear = 0; ir = 32'h0; CON = 0;
    @(posedge clock); #1;
    cyc("rst0", '0, ADD, 1'b0);
    cyc("rst1", '0, ADD, 1'b0);
    clear = 1;
    cyc("rst_release", '0, ADD, 1'b0);
    fetch(32'h61A7FFFB);
    cyc("addi_T3", GRB | ROUT | YIN);
    cyc("addi_T4", COUT | ZIN, 5'd3);
    cyc("addi_T5", ZLOW | GRA | RIN);
    fetch(32'h0000_0000);
    cyc("ld_T3", GRB | BAOUT | YIN);
    cyc("ld_T4", COUT | ZIN);
    cyc("ld_T5", ZLOW | MARIN);
    cyc("ld_T6", MEMREAD | MDRIN | RAMEN);
    cyc("ld_T7", MDROUT | GRA | RIN);
    for (int c = 0; c < 2; c++) begin
      CON = c[0];
      fetch(32'h9800_0000);
      cyc("br_T3", GRA | ROUT | CONIN);
      cyc("br_T4", PCOUT | YIN);
      cyc("br_T5", COUT | ZIN);
      cyc(c ? "br_T6_con1" : "br_T6_con0", c ? ZLOW | PCIN : ZLOW);
    end
    fetch(32'h1000_0000);
    cyc("st_T3", GRB | BAOUT | YIN);
    cyc("st_T4", COUT | ZIN);
    cyc("st_T5", ZLOW | MARIN);
    cyc("st_T6", GRA | ROUT | MDRIN);
    cyc("st_T7", MEMWRITE | RAMEN);
    fetch(32'h5000_0000);
    cyc("and_T3", GRB | ROUT | YIN);
    cyc("and_T4", GRC | ROUT | ZIN, 5'd10);
    cyc("and_T5", ZLOW | GRA | RIN);
    fetch(32'h8800_0000);
    cyc("neg_T3", GRB | ROUT | ZIN, 5'd17);
    cyc("neg_T4", ZLOW | GRA | RIN);
    fetch(32'hA800_0000);
    cyc("jal_T3", PCOUT | R15IN);
    cyc("jal_T4", GRA | ROUT | PCIN);
    fetch(32'hB800_0000);
    cyc("out_T3", GRA | ROUT | OUTP);
    fetch(32'hF000_0000);
    fetch(32'h7800_0000);
    cyc("mul_T3", GRA | ROUT | YIN);
    cyc("mul_T4", GRB | ROUT | ZIN, 5'd15);
    clear = 0;
    cyc("mul_T5", ZLOW | LOIN);
    clear = 1;
    cyc("mul_abort", '0, ADD, 1'b0);
    fetch(32'hD800_0000);
    for (int i = 0; i < 20; i++) cyc("halt_hold", '0, ADD, 1'b0);
    clear = 0;
    cyc("halt_clear", '0, ADD, 1'b0);
    clear = 1;
    ir = 32'hD000_0000;
    cyc("halt_reset", '0, ADD, 1'b0);
    fetch(32'hD000_0000);
    cyc("nop_T0", PCOUT | MARIN | INCPC | ZIN);
    @(negedge clock);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
